instruction_encode_stream: RTL and testbench

// - Inverse of the instruction decoder. Accepts decomposed RV32 instruction fields over a valid/ready stream.
// - Packs the fields into 32-bit instruction words and writes them sequentially into instruction memory.
// - Used as the program loader / self-test generator that fills IMEM before the core leaves reset.

---
 rtl/instruction_encode_stream_pkg.sv | 40 ++++
 rtl/instruction_pack.sv | 48 ++++
 rtl/instruction_encode_stream.sv | 129 ++++++++++++
 tb/tb_instruction_encode_stream.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encode_stream_pkg.sv
// Shared types for the RV32 instruction encoder stream: format selector,
// opcode constants, loader FSM states and the immediate range helper.
package instruction_encode_stream_pkg;

  typedef enum logic [2:0] {
    R_TYPE   = 3'd0,
    I_TYPE   = 3'd1,
    S_TYPE   = 3'd2,
    B_TYPE   = 3'd3,
    U_TYPE   = 3'd4,
    J_TYPE   = 3'd5,
    SYS_TYPE = 3'd6
  } instruction_op_type;

  // Prefixed so the opcode LOAD cannot collide with the FSM state LOAD.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_U_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_J_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } enc_state_t;

  // True when v is representable as a signed value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instruction_pack.sv
// Combinational RV32 field packer. With ENCODE_RANGE_CHECK_EN defined it also
// flags immediates that do not fit the selected format; otherwise excess bits are dropped.
module instruction_pack
  import instruction_encode_stream_pkg::*;
(
  input  instruction_op_type i_optype,
  input  logic [6:0]         i_opcode,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic [2:0]         i_funct3,
  input  logic [6:0]         i_funct7,
  input  logic [31:0]        i_imm,
  output logic [31:0]        o_word,
  output logic               o_range_err
);

  always_comb begin
    o_word = 32'd0;
    case (i_optype)
      R_TYPE:           o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      I_TYPE, SYS_TYPE: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      S_TYPE:           o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      B_TYPE:           o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                                  i_imm[4:1], i_imm[11], i_opcode};
      U_TYPE:           o_word = {i_imm[31:12], i_rd, i_opcode};
      J_TYPE:           o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                                  i_rd, i_opcode};
      default:          o_word = 32'd0;
    endcase
  end

`ifdef ENCODE_RANGE_CHECK_EN
  always_comb begin
    o_range_err = 1'b0;
    case (i_optype)
      I_TYPE, S_TYPE: o_range_err = !fits_signed(i_imm, 12);
      B_TYPE:         o_range_err = !fits_signed(i_imm, 13) || i_imm[0];
      J_TYPE:         o_range_err = !fits_signed(i_imm, 21) || i_imm[0];
      U_TYPE:         o_range_err = |i_imm[11:0];
      default:        o_range_err = 1'b0;
    endcase
  end
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/instruction_encode_stream.sv
// Program loader: packs streamed RV32 field bundles into words and writes them
// sequentially into IMEM through one output register (range checks via ENCODE_RANGE_CHECK_EN).
module instruction_encode_stream
  import instruction_encode_stream_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  instruction_op_type in_optype,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [31:0]        in_imm,
  input  logic               in_last,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [31:0]        imem_wdata,
  input  logic               imem_ready,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    count,
  output logic               err
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

  enc_state_t          r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_retire;
  logic                w_write;
  logic                w_range_err;
  logic [31:0]         w_word;
  logic [ADDR_W:0]     w_count_ret;

  instruction_pack u_pack (
    .i_optype    (in_optype),
    .i_opcode    (in_opcode),
    .i_rd        (in_rd),
    .i_rs1       (in_rs1),
    .i_rs2       (in_rs2),
    .i_funct3    (in_funct3),
    .i_funct7    (in_funct7),
    .i_imm       (in_imm),
    .o_word      (w_word),
    .o_range_err (w_range_err)
  );

  assign in_ready    = (r_state == LOAD) && (!r_we || imem_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_retire    = r_we && imem_ready;
  assign w_write     = w_accept && !w_range_err;
  assign w_count_ret = r_count + {{ADDR_W{1'b0}}, w_retire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= BASE;
      r_wdata <= 32'd0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_retire) begin
        r_count <= w_count_ret;
        r_addr  <= r_addr + 1'b1;
      end
      // A new word replaces the one retiring this cycle; the address has already moved on.
      if (w_write) begin
        r_we    <= 1'b1;
        r_wdata <= w_word;
      end else if (w_retire) begin
        r_we <= 1'b0;
      end
      if (w_accept && w_range_err) r_err <= 1'b1;

      case (r_state)
        IDLE, DONE: begin
          if (r_state == DONE && in_valid) r_err <= 1'b1;
          if (start) begin
            r_state <= LOAD;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
            r_addr  <= BASE;
          end
        end
        LOAD: begin
          // Leave before the window fills so in_ready can never admit word DEPTH+1.
          if (w_accept && (in_last || (w_count_ret + {{ADDR_W{1'b0}}, w_write}) == DEPTH_W))
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_we || w_retire) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state == LOAD) || (r_state == DRAIN);
  assign done       = r_done;
  assign count      = r_count;
  assign err        = r_err;

endmodule

// File: tb/tb_instruction_encode_stream.sv
// Scoreboard bench for instruction_encode_stream: expected IMEM writes are queued
// at accept time and compared when the DUT retires them.
`timescale 1ns/1ps
module tb_instruction_encode_stream;
  import instruction_encode_stream_pkg::*;

  localparam int AW    = 4;
  localparam int BASE  = 2;
  localparam int DEPTH = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  instruction_op_type in_optype;
  logic [6:0]         in_opcode;
  logic [4:0]         in_rd;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic [2:0]         in_funct3;
  logic [6:0]         in_funct7;
  logic [31:0]        in_imm;
  logic               in_last;
  logic               imem_we;
  logic [AW-1:0]      imem_addr;
  logic [31:0]        imem_wdata;
  logic               imem_ready;
  logic               busy;
  logic               done;
  logic [AW:0]        count;
  logic               err;

  always #5 clk = ~clk;

  instruction_encode_stream #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_optype  (in_optype),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ready (imem_ready),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .err        (err)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [AW+31:0] sb[$];
  logic [AW-1:0] m_addr;
  logic [AW+31:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Each retired write is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      mon_exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
      check("wr_addr", imem_addr, mon_exp[AW+31:32]);
      check("wr_data", imem_wdata, mon_exp[31:0]);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input instruction_op_type op, input logic [6:0] opc,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input logic last, input logic [31:0] exp_word, input logic exp_write);
    int waited = 0;
    in_optype = op; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", waited, 0);
    else if (exp_write) begin
      sb.push_back({m_addr, exp_word});
      m_addr++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    m_addr = AW'(BASE);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
    in_optype = R_TYPE; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; in_last = 1'b0;
    m_addr = AW'(BASE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // addi x1,x0,5 as a one-word program
    do_start();
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("count_after_start", count, 0);
    @(posedge clk); #1;
    send(I_TYPE, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 1'b1);
    @(negedge clk);
    check("lat1_we", imem_we, 1);
    wait_done("done_addi");
    check("count_addi", count, 1);

    // five-instruction program, start pulsed mid-load must be ignored
    do_start();
    send(R_TYPE, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'h002081B3, 1'b1);
    start = 1'b1;
    send(S_TYPE, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020A423, 1'b1);
    start = 1'b0;
    send(B_TYPE, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 32'hFE000EE3, 1'b1);
    send(U_TYPE, OPC_U_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 32'h123452B7, 1'b1);
    send(J_TYPE, OPC_J_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0000006F, 1'b1);
    wait_done("done_prog");
    check("count_prog", count, 5);
    check("busy_prog", busy, 0);

    // fill the whole window without in_last
    do_start();
    for (int i = 0; i < DEPTH; i++)
      send(I_TYPE, OPC_OP_IMM, 5'(i + 1), 5'(i), 5'd0, 3'd0, 7'd0, 32'(i * 7), 1'b0,
           (32'(i * 7) << 20) | (32'(i) << 15) | (32'(i + 1) << 7) | 32'h13, 1'b1);
    wait_done("done_full");
    check("count_full", count, DEPTH);
    check("addr_full", imem_addr, BASE + DEPTH);
    check("ready_full", in_ready, 0);
    check("err_before_extra", err, 0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("err_extra", err, 1);
    check("ready_extra", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b0;

    // IMEM back-pressure: held word must stay stable, next word waits
    do_start();
    imem_ready = 1'b0;
    send(R_TYPE, OPC_OP, 5'd7, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0, 1'b0, 32'h406283B3, 1'b1);
    fork
      send(S_TYPE, OPC_STORE, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFFFFF4, 1'b1, 32'hFE41AA23, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_ready", in_ready, 0);
          check("stall_addr", imem_addr, BASE);
          check("stall_data", imem_wdata, 32'h406283B3);
        end
        @(posedge clk); #1 imem_ready = 1'b1;
      end
    join
    wait_done("done_stall");
    check("count_stall", count, 2);
    check("err_cleared", err, 0);

`ifdef ENCODE_RANGE_CHECK_EN
    do_start();
    send(I_TYPE, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("rc_err_i", err, 1);
    check("rc_we_i", imem_we, 0);
    check("rc_count_i", count, 0);
    @(posedge clk); #1;
    send(B_TYPE, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("rc_we_b", imem_we, 0);
    @(posedge clk); #1;
    send(I_TYPE, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 1'b1);
    wait_done("done_rc");
    check("count_rc", count, 1);
    check("err_rc_sticky", err, 1);
`else
    do_start();
    send(I_TYPE, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001005, 1'b1, 32'h00500093, 1'b1);
    wait_done("done_trunc");
    check("count_trunc", count, 1);
    check("err_trunc", err, 0);
`endif

    // reset while a write is stalled
    do_start();
    imem_ready = 1'b0;
    send(U_TYPE, OPC_U_LUI, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b0, 32'hABCDE4B7, 1'b1);
    @(negedge clk);
    check("pre_rst_we", imem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 0);
    check("arst_we", imem_we, 0);
    check("arst_addr", imem_addr, BASE);
    check("arst_wdata", imem_wdata, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_count", count, 0);
    check("arst_err", err, 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1; imem_ready = 1'b1;
    do_start();
    send(J_TYPE, OPC_J_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 1'b1, 32'h001000EF, 1'b1);
    wait_done("done_after_rst");
    check("count_after_rst", count, 1);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
